// File: rtl/snax_tcdm_credit_adapter.sv
// TCDM port adapter with per-port read credit tracking and drain/barrier FSM.
// Define SNAX_TCDM_ADAPTER_REQ_REG_EN to insert a 1-entry elastic request register per port.
module snax_tcdm_credit_adapter #(
  parameter int unsigned NumPorts       = 24,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned AddrWidth      = 48,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned CoreId         = 0
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumPorts-1:0]               acc_req_valid_i,
  output logic [NumPorts-1:0]               acc_req_ready_o,
  input  logic [NumPorts-1:0]               acc_req_write_i,
  input  logic [NumPorts*AddrWidth-1:0]     acc_req_addr_i,
  input  logic [NumPorts*DataWidth-1:0]     acc_req_data_i,
  input  logic [NumPorts*(DataWidth/8)-1:0] acc_req_strb_i,
  output logic [NumPorts-1:0]               acc_rsp_valid_o,
  output logic [NumPorts*DataWidth-1:0]     acc_rsp_data_o,
  output logic [NumPorts-1:0]               tcdm_req_q_valid_o,
  input  logic [NumPorts-1:0]               tcdm_rsp_q_ready_i,
  output logic [NumPorts-1:0]               tcdm_req_write_o,
  output logic [NumPorts*AddrWidth-1:0]     tcdm_req_addr_o,
  output logic [NumPorts*DataWidth-1:0]     tcdm_req_data_o,
  output logic [NumPorts*(DataWidth/8)-1:0] tcdm_req_strb_o,
  output logic [NumPorts*4-1:0]             tcdm_req_amo_o,
  output logic [NumPorts*5-1:0]             tcdm_req_user_core_id_o,
  output logic [NumPorts-1:0]               tcdm_req_user_is_core_o,
  input  logic [NumPorts-1:0]               tcdm_rsp_p_valid_i,
  input  logic [NumPorts*DataWidth-1:0]     tcdm_rsp_data_i,
  input  logic                              drain_i,
  output logic                              barrier_o,
  output logic                              idle_o,
  output logic [NumPorts-1:0]               err_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned CntWidth  = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0] CntMax     = CntWidth'(MaxOutstanding);
  localparam logic [4:0]          CoreIdBits = 5'(CoreId);

  typedef enum logic [1:0] {Run, Draining, Drained} state_e;

  state_e              state_q, state_d;
  logic [CntWidth-1:0] count_q [NumPorts];
  logic [NumPorts-1:0] err_q;
  logic [NumPorts-1:0] full, cnt_zero, gate, take;
  logic                run_ok, pending;

  // Accept and return in the same cycle cancel; the counter saturates at both ends.
  function automatic logic [CntWidth-1:0] credit_next(input logic [CntWidth-1:0] cnt,
                                                      input logic take_c, input logic give_c);
    logic [CntWidth-1:0] nxt;
    nxt = cnt;
    if (take_c && !give_c && cnt != CntMax) nxt = cnt + CntWidth'(1);
    else if (give_c && !take_c && cnt != '0) nxt = cnt - CntWidth'(1);
    return nxt;
  endfunction

  always_comb begin
    full     = '0;
    cnt_zero = '0;
    for (int i = 0; i < NumPorts; i++) begin
      full[i]     = (count_q[i] >= CntMax);
      cnt_zero[i] = (count_q[i] == '0);
    end
  end

  assign run_ok = (state_q == Run) && !rst_i;

`ifdef SNAX_TCDM_ADAPTER_REQ_REG_EN
  logic [NumPorts-1:0]           req_vld_p1;
  logic [NumPorts-1:0]           req_write_p1;
  logic [NumPorts*AddrWidth-1:0] req_addr_p1;
  logic [NumPorts*DataWidth-1:0] req_data_p1;
  logic [NumPorts*StrbWidth-1:0] req_strb_p1;
  logic [NumPorts-1:0]           accept, issue;

  assign gate               = req_write_p1 | ~full;
  assign tcdm_req_q_valid_o = req_vld_p1 & gate & {NumPorts{!rst_i}};
  assign issue              = tcdm_req_q_valid_o & tcdm_rsp_q_ready_i;
  assign acc_req_ready_o    = (~req_vld_p1 | issue) & {NumPorts{run_ok}};
  assign accept             = acc_req_valid_i & acc_req_ready_o;

  // Stage p0 -> p1: elastic request register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_vld_p1 <= '0;
    end else begin
      for (int i = 0; i < NumPorts; i++) begin
        if (accept[i])     req_vld_p1[i] <= 1'b1;
        else if (issue[i]) req_vld_p1[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NumPorts; i++) begin
      if (accept[i]) begin
        req_write_p1[i]                       <= acc_req_write_i[i];
        req_addr_p1[i*AddrWidth +: AddrWidth] <= acc_req_addr_i[i*AddrWidth +: AddrWidth];
        req_data_p1[i*DataWidth +: DataWidth] <= acc_req_data_i[i*DataWidth +: DataWidth];
        req_strb_p1[i*StrbWidth +: StrbWidth] <= acc_req_strb_i[i*StrbWidth +: StrbWidth];
      end
    end
  end

  assign tcdm_req_write_o = req_write_p1;
  assign tcdm_req_addr_o  = req_addr_p1;
  assign tcdm_req_data_o  = req_data_p1;
  assign tcdm_req_strb_o  = req_strb_p1;
  assign pending          = |req_vld_p1;
`else
  assign gate               = acc_req_write_i | ~full;
  assign tcdm_req_q_valid_o = acc_req_valid_i & gate & {NumPorts{run_ok}};
  assign acc_req_ready_o    = tcdm_rsp_q_ready_i & gate & {NumPorts{run_ok}};
  assign tcdm_req_write_o   = acc_req_write_i;
  assign tcdm_req_addr_o    = acc_req_addr_i;
  assign tcdm_req_data_o    = acc_req_data_i;
  assign tcdm_req_strb_o    = acc_req_strb_i;
  assign pending            = 1'b0;
`endif

  assign take = tcdm_req_q_valid_o & tcdm_rsp_q_ready_i & ~tcdm_req_write_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumPorts; i++) count_q[i] <= '0;
      err_q <= '0;
    end else begin
      for (int i = 0; i < NumPorts; i++)
        count_q[i] <= credit_next(count_q[i], take[i], tcdm_rsp_p_valid_i[i]);
      err_q <= err_q | (tcdm_rsp_p_valid_i & cnt_zero);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= Run;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Run:      if (drain_i) state_d = Draining;
      Draining: if (!drain_i) state_d = Run;
                else if (idle_o) state_d = Drained;
      Drained:  if (!drain_i) state_d = Run;
      default:  state_d = Run;
    endcase
  end

  assign idle_o    = rst_i || ((&cnt_zero) && !pending);
  assign barrier_o = (state_q == Drained);
  assign err_o     = err_q;

  assign acc_rsp_valid_o = tcdm_rsp_p_valid_i & {NumPorts{!rst_i}};
  assign acc_rsp_data_o  = tcdm_rsp_data_i;

  assign tcdm_req_amo_o          = '0;
  assign tcdm_req_user_core_id_o = {NumPorts{CoreIdBits}};
  assign tcdm_req_user_is_core_o = '0;

endmodule

// File: tb/tb_snax_tcdm_credit_adapter.sv
// Directed bench for snax_tcdm_credit_adapter (default combinational request path).
module tb_snax_tcdm_credit_adapter;

  localparam int NP  = 8;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int SW  = DW / 8;
  localparam int MO  = 2;
  localparam int CID = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     acc_req_valid, acc_req_ready, acc_req_write;
  logic [NP*AW-1:0]  acc_req_addr;
  logic [NP*DW-1:0]  acc_req_data;
  logic [NP*SW-1:0]  acc_req_strb;
  logic [NP-1:0]     acc_rsp_valid;
  logic [NP*DW-1:0]  acc_rsp_data;
  logic [NP-1:0]     q_valid, q_ready, tcdm_write;
  logic [NP*AW-1:0]  tcdm_addr;
  logic [NP*DW-1:0]  tcdm_data;
  logic [NP*SW-1:0]  tcdm_strb;
  logic [NP*4-1:0]   tcdm_amo;
  logic [NP*5-1:0]   tcdm_core_id;
  logic [NP-1:0]     tcdm_is_core;
  logic [NP-1:0]     p_valid;
  logic [NP*DW-1:0]  rsp_data;
  logic              drain, barrier, idle;
  logic [NP-1:0]     err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  snax_tcdm_credit_adapter #(
    .NumPorts(NP), .DataWidth(DW), .AddrWidth(AW), .MaxOutstanding(MO), .CoreId(CID)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .acc_req_valid_i(acc_req_valid), .acc_req_ready_o(acc_req_ready),
    .acc_req_write_i(acc_req_write), .acc_req_addr_i(acc_req_addr),
    .acc_req_data_i(acc_req_data), .acc_req_strb_i(acc_req_strb),
    .acc_rsp_valid_o(acc_rsp_valid), .acc_rsp_data_o(acc_rsp_data),
    .tcdm_req_q_valid_o(q_valid), .tcdm_rsp_q_ready_i(q_ready),
    .tcdm_req_write_o(tcdm_write), .tcdm_req_addr_o(tcdm_addr),
    .tcdm_req_data_o(tcdm_data), .tcdm_req_strb_o(tcdm_strb),
    .tcdm_req_amo_o(tcdm_amo), .tcdm_req_user_core_id_o(tcdm_core_id),
    .tcdm_req_user_is_core_o(tcdm_is_core),
    .tcdm_rsp_p_valid_i(p_valid), .tcdm_rsp_data_i(rsp_data),
    .drain_i(drain), .barrier_o(barrier), .idle_o(idle), .err_o(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    acc_req_valid = '0; acc_req_write = '0; acc_req_addr = '0;
    acc_req_data = '0; acc_req_strb = '0; q_ready = '0;
    p_valid = '0; rsp_data = '0; drain = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1; acc_req_valid = '1; q_ready = '1; p_valid = '1;
    tick(); tick();
    n_checks++; if (acc_req_ready !== 8'h00) begin n_fail++; $display("FAIL reset_ready: got %h want 00", acc_req_ready); end
    n_checks++; if (q_valid !== 8'h00) begin n_fail++; $display("FAIL reset_qvalid: got %h want 00", q_valid); end
    n_checks++; if (acc_rsp_valid !== 8'h00) begin n_fail++; $display("FAIL reset_rspvalid: got %h want 00", acc_rsp_valid); end
    n_checks++; if (barrier !== 1'b0) begin n_fail++; $display("FAIL reset_barrier: got %b want 0", barrier); end
    rst = 1'b0; clear_inputs();
    #1;
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle); end
    n_checks++; if (err !== 8'h00) begin n_fail++; $display("FAIL reset_err: got %h want 00", err); end
    n_checks++; if (tcdm_amo !== 32'h0) begin n_fail++; $display("FAIL const_amo: got %h want 0", tcdm_amo); end
    n_checks++; if (tcdm_core_id !== {NP{5'd3}}) begin n_fail++; $display("FAIL const_core_id: got %h want %h", tcdm_core_id, {NP{5'd3}}); end
    n_checks++; if (tcdm_is_core !== 8'h00) begin n_fail++; $display("FAIL const_is_core: got %h want 00", tcdm_is_core); end
  endtask

  task automatic test_credit_gate();
    clear_inputs();
    acc_req_valid[0] = 1'b1; q_ready[0] = 1'b1; acc_req_addr[0 +: AW] = 32'h100;
    #1;
    n_checks++; if (q_valid[0] !== 1'b1 || acc_req_ready[0] !== 1'b1) begin n_fail++; $display("FAIL gate_read1: valid %b ready %b want 1 1", q_valid[0], acc_req_ready[0]); end
    tick();
    n_checks++; if (q_valid[0] !== 1'b1) begin n_fail++; $display("FAIL gate_read2: got %b want 1", q_valid[0]); end
    tick();
    n_checks++; if (q_valid[0] !== 1'b0 || acc_req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL gate_read3_held: valid %b ready %b want 0 0", q_valid[0], acc_req_ready[0]); end
    tick();
    n_checks++; if (q_valid[0] !== 1'b0) begin n_fail++; $display("FAIL gate_count_holds: got %b want 0", q_valid[0]); end
    p_valid[0] = 1'b1; rsp_data[0 +: DW] = 32'hDEAD0001;
    #1;
    n_checks++; if (acc_rsp_valid[0] !== 1'b1 || acc_rsp_data[0 +: DW] !== 32'hDEAD0001) begin n_fail++; $display("FAIL gate_rsp_fwd: valid %b data %h want 1 dead0001", acc_rsp_valid[0], acc_rsp_data[0 +: DW]); end
    n_checks++; if (q_valid[0] !== 1'b0) begin n_fail++; $display("FAIL gate_same_cycle_as_rsp: got %b want 0", q_valid[0]); end
    tick();
    p_valid = '0;
    #1;
    n_checks++; if (q_valid[0] !== 1'b1) begin n_fail++; $display("FAIL gate_read3_issue: got %b want 1", q_valid[0]); end
    tick();
    acc_req_valid = '0; p_valid[0] = 1'b1;
    #1;
    n_checks++; if (idle !== 1'b0) begin n_fail++; $display("FAIL gate_busy: idle %b want 0", idle); end
    tick(); tick();
    p_valid = '0;
    #1;
    n_checks++; if (idle !== 1'b1 || err !== 8'h00) begin n_fail++; $display("FAIL gate_drained: idle %b err %h want 1 00", idle, err); end
  endtask

  task automatic test_same_cycle();
    clear_inputs();
    acc_req_valid[3] = 1'b1; q_ready[3] = 1'b1;
    #1;
    n_checks++; if (q_valid[3] !== 1'b1) begin n_fail++; $display("FAIL same_first: got %b want 1", q_valid[3]); end
    tick();
    p_valid[3] = 1'b1;
    #1;
    n_checks++; if (q_valid[3] !== 1'b1) begin n_fail++; $display("FAIL same_accept_and_ret: got %b want 1", q_valid[3]); end
    tick();
    p_valid = '0;
    #1;
    n_checks++; if (q_valid[3] !== 1'b1 || acc_req_ready[3] !== 1'b1) begin n_fail++; $display("FAIL same_count_one: valid %b ready %b want 1 1", q_valid[3], acc_req_ready[3]); end
    tick();
    n_checks++; if (q_valid[3] !== 1'b0 || err[3] !== 1'b0) begin n_fail++; $display("FAIL same_count_two: valid %b err %b want 0 0", q_valid[3], err[3]); end
    acc_req_valid = '0; p_valid[3] = 1'b1;
    tick(); tick();
    p_valid = '0;
    #1;
    n_checks++; if (idle !== 1'b1 || err !== 8'h00) begin n_fail++; $display("FAIL same_end: idle %b err %h want 1 00", idle, err); end
  endtask

  task automatic test_unexpected_rsp();
    clear_inputs();
    p_valid[5] = 1'b1; rsp_data[5*DW +: DW] = 32'hCAFE0005;
    #1;
    n_checks++; if (acc_rsp_valid !== 8'h20 || acc_rsp_data[5*DW +: DW] !== 32'hCAFE0005) begin n_fail++; $display("FAIL unexp_fwd: valid %h data %h want 20 cafe0005", acc_rsp_valid, acc_rsp_data[5*DW +: DW]); end
    tick();
    p_valid = '0;
    #1;
    n_checks++; if (err !== 8'h20) begin n_fail++; $display("FAIL unexp_err_set: got %h want 20", err); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL unexp_count_zero: idle %b want 1", idle); end
    tick(); tick();
    n_checks++; if (err !== 8'h20) begin n_fail++; $display("FAIL unexp_err_sticky: got %h want 20", err); end
  endtask

  task automatic test_drain();
    clear_inputs();
    q_ready = '1; acc_req_valid[1] = 1'b1;
    tick(); tick();
    acc_req_valid = '0; drain = 1'b1;
    tick();
    acc_req_valid[2] = 1'b1; acc_req_write[2] = 1'b1;
    #1;
    n_checks++; if (acc_req_ready !== 8'h00 || q_valid !== 8'h00) begin n_fail++; $display("FAIL drain_ready_off: ready %h qvalid %h want 00 00", acc_req_ready, q_valid); end
    n_checks++; if (barrier !== 1'b0 || idle !== 1'b0) begin n_fail++; $display("FAIL drain_pending: barrier %b idle %b want 0 0", barrier, idle); end
    p_valid[1] = 1'b1;
    tick(); tick();
    p_valid = '0;
    #1;
    n_checks++; if (idle !== 1'b1 || barrier !== 1'b0) begin n_fail++; $display("FAIL drain_idle: idle %b barrier %b want 1 0", idle, barrier); end
    tick();
    n_checks++; if (barrier !== 1'b1 || acc_req_ready !== 8'h00) begin n_fail++; $display("FAIL drain_barrier_on: barrier %b ready %h want 1 00", barrier, acc_req_ready); end
    drain = 1'b0;
    #1;
    n_checks++; if (barrier !== 1'b1) begin n_fail++; $display("FAIL drain_barrier_hold: got %b want 1", barrier); end
    tick();
    n_checks++; if (barrier !== 1'b0 || q_valid[2] !== 1'b1 || acc_req_ready[2] !== 1'b1) begin n_fail++; $display("FAIL drain_resume: barrier %b qv %b rdy %b want 0 1 1", barrier, q_valid[2], acc_req_ready[2]); end
    n_checks++; if (err !== 8'h20) begin n_fail++; $display("FAIL drain_err: got %h want 20", err); end
    clear_inputs();
  endtask

  task automatic test_writes();
    logic [NP-1:0] taken;
    clear_inputs();
    acc_req_valid = '1; acc_req_write = '1;
    taken = '1;
    for (int c = 0; c < 100; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (taken[p]) begin
          acc_req_addr[p*AW +: AW] = $urandom;
          acc_req_data[p*DW +: DW] = $urandom;
          acc_req_strb[p*SW +: SW] = SW'($urandom);
        end
      end
      q_ready = NP'($urandom);
      #1;
      n_checks++; if (q_valid !== 8'hFF) begin n_fail++; $display("FAIL wr_valid c%0d: got %h want ff", c, q_valid); end
      n_checks++; if (acc_req_ready !== q_ready) begin n_fail++; $display("FAIL wr_ready c%0d: got %h want %h", c, acc_req_ready, q_ready); end
      n_checks++; if (tcdm_addr !== acc_req_addr || tcdm_data !== acc_req_data) begin n_fail++; $display("FAIL wr_payload c%0d: addr %h data %h want %h %h", c, tcdm_addr, tcdm_data, acc_req_addr, acc_req_data); end
      n_checks++; if (tcdm_strb !== acc_req_strb || tcdm_write !== 8'hFF) begin n_fail++; $display("FAIL wr_strb c%0d: strb %h wr %h want %h ff", c, tcdm_strb, tcdm_write, acc_req_strb); end
      n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL wr_no_credit c%0d: idle %b want 1", c, idle); end
      taken = q_ready;
      tick();
    end
    clear_inputs();
    #1;
    n_checks++; if (idle !== 1'b1 || err !== 8'h20) begin n_fail++; $display("FAIL wr_end: idle %b err %h want 1 20", idle, err); end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    q_ready = '1; acc_req_valid[0] = 1'b1; acc_req_valid[1] = 1'b1;
    tick();
    acc_req_valid[1] = 1'b0;
    tick();
    acc_req_valid = '0; drain = 1'b1;
    tick();
    n_checks++; if (idle !== 1'b0 || barrier !== 1'b0) begin n_fail++; $display("FAIL rmid_pre: idle %b barrier %b want 0 0", idle, barrier); end
    rst = 1'b1; drain = 1'b0; acc_req_valid[0] = 1'b1;
    #1;
    n_checks++; if (q_valid !== 8'h00 || acc_req_ready !== 8'h00) begin n_fail++; $display("FAIL rmid_in_reset: qv %h rdy %h want 00 00", q_valid, acc_req_ready); end
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (idle !== 1'b1 || err !== 8'h00 || barrier !== 1'b0) begin n_fail++; $display("FAIL rmid_cleared: idle %b err %h barrier %b want 1 00 0", idle, err, barrier); end
    n_checks++; if (acc_req_ready !== 8'hFF) begin n_fail++; $display("FAIL rmid_run_state: ready %h want ff", acc_req_ready); end
    n_checks++; if (q_valid !== 8'h01) begin n_fail++; $display("FAIL rmid_first_read: got %h want 01", q_valid); end
    tick();
    n_checks++; if (q_valid[0] !== 1'b1 || idle !== 1'b0) begin n_fail++; $display("FAIL rmid_second_read: qv %b idle %b want 1 0", q_valid[0], idle); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_credit_gate();
    test_same_cycle();
    test_unexpected_rsp();
    test_drain();
    test_writes();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
